piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out stage: accepts a WIDTH-bit word over a valid/ready
//  handshake and emits it one bit per accepted beat, stepping a bit-select
//  index through the word. Sits upstream of the 8:1 bit-select datapath.
//  Drives the select index, consumes the selected bit and presents it as a
//  handshaked serial stream to the downstream consumer.
// PARAMETERS
//  WIDTH      8                 word width in bits; >= 2
//  SEL_W      $clog2(WIDTH)     bit-index width (derived; do not override)
//  MSB_FIRST  0                 0: bit 0 first; 1: bit WIDTH-1 first
// PORTS
//  clk        in   1      single clock; all state updates on posedge
//  rst        in   1      synchronous, active-high reset
//  in_data    in   WIDTH  parallel word
//  in_valid   in   1      in_data valid
//  in_ready   out  1      serializer can accept a word this cycle
//  ser_data   out  1      current serial bit
//  ser_valid  out  1      ser_data valid
//  ser_ready  in   1      downstream accepts ser_data this cycle
//  ser_last   out  1      high with the final bit of the word
//  bit_idx    out  SEL_W  index of the bit currently presented (select feed)
//  busy       out  1      high while in SHIFT
// BEHAVIOUR
//  - One clock (clk); reset is synchronous and active-high (rst).
//  - Reset: state=IDLE, hold reg=0, count=0. Outputs read ser_valid=0,
//    ser_data=0, ser_last=0, busy=0 and bit_idx=0. in_ready=0 while rst=1.
//  - Reset mid-word: the word is discarded, with no partial ser_last.
//    IDLE on the next cycle.
//  - FSM states IDLE and SHIFT, encoded with the package enum.
//  - IDLE: in_ready=1. On in_valid&&in_ready, capture in_data into the hold
//    reg and load count=0. Move to SHIFT.
//  - SHIFT: ser_valid=1; ser_data=hold[bit_idx], selected combinationally.
//  - bit_idx is count when MSB_FIRST=0, and WIDTH-1-count when MSB_FIRST=1.
//  - In SHIFT, ser_valid&&ser_ready advances count by 1.
//  - Stall: ser_valid&&!ser_ready holds ser_data, bit_idx and ser_last
//    stable. ser_valid may not drop.
//  - ser_last = SHIFT && count==WIDTH-1.
//  - Last beat accepted, in_valid=0: go to IDLE. ser_valid=0 next cycle.
//  - Back-to-back: on the last beat, in_ready = ser_ready (combinational).
//    If in_valid is also high, the new word is captured and count=0. Stay
//    in SHIFT; the first bit of the new word follows with no bubble.
//  - Latency: word accepted in cycle N -> first bit valid in cycle N+1.
//  - Throughput: WIDTH cycles per word at ser_ready=1.
//  - in_data is ignored outside a handshake; the hold reg changes only on
//    capture.
//  - count never exceeds WIDTH-1; no wrap is visible outside.
// STRUCTURE
//  - Package piso_pkg: typedef enum logic {IDLE, SHIFT} piso_state_t;
//    localparam DEF_WIDTH=8.
//  - Sub-module piso_bit_select: combinational WIDTH:1 select,
//    (word, idx) -> bit. It is the only place indexing the hold reg.
//  - Top holds the FSM, count, hold reg and handshake logic; all regs use
//    one always_ff with sync reset.
// TESTING
//  - Reset, then in_data=8'hA5, ser_ready=1, MSB_FIRST=0.
//    -> ser_data 1,0,1,0,0,1,0,1 over 8 cycles; bit_idx 0..7; ser_last on
//    beat 8 only.
//  - MSB_FIRST=1, word 8'h81.
//    -> bits 1,0,0,0,0,0,0,1; bit_idx 7..0.
//  - Word 8'h3C, ser_ready low 3 cycles at beat 4.
//    -> ser_data/bit_idx frozen at idx 3; stream resumes, 8 bits, none
//    lost or duplicated.
//  - Words 8'hFF then 8'h00 with in_valid held high.
//    -> 16 consecutive valid beats; in_ready high only on beat 8;
//    no idle cycle between words.
//  - rst=1 at beat 5 of 8'hF0.
//    -> ser_valid=0 next cycle; no ser_last. Next word 8'h0F serializes
//    fully from idx 0.
//  - in_valid=1 while busy and not on the last beat.
//    -> in_ready=0; in_data changes have no effect on the serial output.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// Holds the FSM state encoding and the bit-order mapping used by the top.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } piso_state_t;

  localparam int DEF_WIDTH = 8;

  // Map a beat counter to the bit position it presents, honouring bit order.
  function automatic int unsigned sel_index(input int unsigned count,
                                            input int unsigned width,
                                            input bit          msb_first);
    if (msb_first) begin
      return width - 32'd1 - count;
    end else begin
      return count;
    end
  endfunction

endpackage

// File: rtl/piso_bit_select.sv
// Combinational WIDTH:1 bit select feeding the serial output.
// The only place the hold register is indexed.
module piso_bit_select
  import piso_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [SEL_W-1:0] idx,
  output logic             bit_out
);

  // Select one bit of the word; an out-of-range index reads as zero.
  always_comb begin
    bit_out = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (idx == SEL_W'(i)) begin
        bit_out = word[i];
      end else begin
        bit_out = bit_out;
      end
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: captures a word over valid/ready and streams
// it one bit per accepted beat, driving the bit-select index alongside.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int SEL_W     = $clog2(WIDTH),
  parameter int MSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic [SEL_W-1:0] bit_idx,
  output logic             busy
);

  localparam logic [SEL_W-1:0] LAST_COUNT = SEL_W'(WIDTH - 1);

  piso_state_t      state_r;
  logic [WIDTH-1:0] hold_r;
  logic [SEL_W-1:0] count_r;

  logic             shifting_s;
  logic             at_last_s;
  logic             beat_s;
  logic             capture_s;
  logic [SEL_W-1:0] sel_idx_s;
  logic             sel_bit_s;

  assign shifting_s = (state_r == SHIFT);
  assign at_last_s  = shifting_s && (count_r == LAST_COUNT);
  assign beat_s     = shifting_s && ser_ready;
  assign capture_s  = in_valid && in_ready;
  assign sel_idx_s  = SEL_W'(sel_index(32'(count_r), 32'(WIDTH), MSB_FIRST != 0));

  // Accept a new word when idle, or on the last beat when downstream takes it.
  always_comb begin
    if (rst) begin
      in_ready = 1'b0;
    end else if (state_r == IDLE) begin
      in_ready = 1'b1;
    end else if (at_last_s) begin
      in_ready = ser_ready;
    end else begin
      in_ready = 1'b0;
    end
  end

  piso_bit_select #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_bit_select (
    .word    (hold_r),
    .idx     (sel_idx_s),
    .bit_out (sel_bit_s)
  );

  // Serial-side outputs are decoded only from registered state.
  always_comb begin
    if (shifting_s) begin
      ser_valid = 1'b1;
      busy      = 1'b1;
      ser_data  = sel_bit_s;
      bit_idx   = sel_idx_s;
      ser_last  = at_last_s;
    end else begin
      ser_valid = 1'b0;
      busy      = 1'b0;
      ser_data  = 1'b0;
      bit_idx   = '0;
      ser_last  = 1'b0;
    end
  end

  // FSM, beat counter and hold register; a reset mid-word drops the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      hold_r  <= '0;
      count_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (capture_s) begin
            hold_r  <= in_data;
            count_r <= '0;
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (beat_s && at_last_s) begin
            count_r <= '0;
            if (capture_s) begin
              // Back-to-back: next word's first bit follows with no bubble.
              hold_r  <= in_data;
              state_r <= SHIFT;
            end else begin
              state_r <= IDLE;
            end
          end else if (beat_s) begin
            count_r <= count_r + SEL_W'(1);
          end else begin
            count_r <= count_r;
          end
        end
        default: begin
          state_r <= IDLE;
          count_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: LSB-first and MSB-first instances,
// checked each cycle against a scoreboard of expected serial beats.
module tb_piso_serializer;

  typedef struct packed {
    logic       data;
    logic [2:0] idx;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data   [2];
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic       ser_data  [2];
  logic       ser_valid [2];
  logic       ser_ready [2];
  logic       ser_last  [2];
  logic [2:0] bit_idx   [2];
  logic       busy      [2];

  beat_t sb0[$];
  beat_t sb1[$];
  int    passed = 0;
  int    total  = 0;
  logic  cap        [2];
  logic  stall_prev [2];
  logic  prev_data  [2];
  logic  prev_last  [2];
  logic [2:0] prev_idx [2];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .ser_data(ser_data[0]), .ser_valid(ser_valid[0]),
    .ser_ready(ser_ready[0]), .ser_last(ser_last[0]), .bit_idx(bit_idx[0]),
    .busy(busy[0])
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .ser_data(ser_data[1]), .ser_valid(ser_valid[1]),
    .ser_ready(ser_ready[1]), .ser_last(ser_last[1]), .bit_idx(bit_idx[1]),
    .busy(busy[1])
  );

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? sb0.size() : sb1.size();
  endfunction

  task automatic push_word(input int k, input logic [7:0] w);
    beat_t b;
    for (int i = 0; i < 8; i++) begin
      b.idx  = (k != 0) ? 3'(7 - i) : 3'(i);
      b.data = w[b.idx];
      b.last = (i == 7);
      if (k == 0) sb0.push_back(b);
      else        sb1.push_back(b);
    end
  endtask

  // Per-cycle monitor for one instance, evaluated at the falling edge.
  task automatic mon(input int k);
    int    n;
    beat_t eb;
    logic  exp_rdy;
    n = qsize(k);
    if (rst) begin
      chk("rst_in_ready", k, 32'(in_ready[k]), 32'd0);
      if (k == 0) sb0.delete();
      else        sb1.delete();
      stall_prev[k] = 1'b0;
      cap[k]        = 1'b0;
      return;
    end
    exp_rdy = (n == 0) || (n == 1 && ser_ready[k]);
    chk("in_ready",  k, 32'(in_ready[k]),  32'(exp_rdy));
    chk("ser_valid", k, 32'(ser_valid[k]), 32'(n != 0));
    chk("busy",      k, 32'(busy[k]),      32'(n != 0));
    if (stall_prev[k]) begin
      chk("stall_data", k, 32'(ser_data[k]), 32'(prev_data[k]));
      chk("stall_idx",  k, 32'(bit_idx[k]),  32'(prev_idx[k]));
      chk("stall_last", k, 32'(ser_last[k]), 32'(prev_last[k]));
    end
    if (n != 0) begin
      eb = (k == 0) ? sb0[0] : sb1[0];
      chk("ser_data", k, 32'(ser_data[k]), 32'(eb.data));
      chk("bit_idx",  k, 32'(bit_idx[k]),  32'(eb.idx));
      chk("ser_last", k, 32'(ser_last[k]), 32'(eb.last));
      if (ser_ready[k]) begin
        if (k == 0) void'(sb0.pop_front());
        else        void'(sb1.pop_front());
      end
    end else begin
      chk("idle_data", k, 32'(ser_data[k]), 32'd0);
      chk("idle_last", k, 32'(ser_last[k]), 32'd0);
      chk("idle_idx",  k, 32'(bit_idx[k]),  32'd0);
    end
    stall_prev[k] = ser_valid[k] && !ser_ready[k];
    prev_data[k]  = ser_data[k];
    prev_idx[k]   = bit_idx[k];
    prev_last[k]  = ser_last[k];
    cap[k]        = in_valid[k] && in_ready[k];
    if (cap[k]) push_word(k, in_data[k]);
  endtask

  task automatic tick();
    @(negedge clk);
    mon(0);
    mon(1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic [7:0] w, input bit keep);
    int n;
    in_valid[k] = 1'b1;
    in_data[k]  = w;
    n = 0;
    do begin
      tick();
      n++;
    end while (!cap[k] && n < 40);
    if (!cap[k]) chk("send_timeout", k, 32'd0, 32'd1);
    if (!keep) in_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while (qsize(k) != 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain", k, 32'(qsize(k)), 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data[k]    = 8'h00;
      in_valid[k]   = 1'b0;
      ser_ready[k]  = 1'b1;
      cap[k]        = 1'b0;
      stall_prev[k] = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      chk("reset_valid", k, 32'(ser_valid[k]), 32'd0);
      chk("reset_data",  k, 32'(ser_data[k]),  32'd0);
      chk("reset_last",  k, 32'(ser_last[k]),  32'd0);
      chk("reset_busy",  k, 32'(busy[k]),      32'd0);
      chk("reset_idx",   k, 32'(bit_idx[k]),   32'd0);
      chk("reset_ready", k, 32'(in_ready[k]),  32'd0);
    end
    rst = 1'b0;
    tick();

    // LSB-first A5, then MSB-first 81.
    send(0, 8'hA5, 1'b0);
    drain(0);
    send(1, 8'h81, 1'b0);
    drain(1);

    // Stall three cycles while bit index 3 is presented.
    send(0, 8'h3C, 1'b0);
    repeat (3) tick();
    ser_ready[0] = 1'b0;
    repeat (3) tick();
    ser_ready[0] = 1'b1;
    drain(0);

    // Back-to-back words with in_valid held high.
    send(0, 8'hFF, 1'b1);
    send(0, 8'h00, 1'b1);
    in_valid[0] = 1'b0;
    drain(0);

    // Reset during beat 5 of F0, then a full 0F with noisy in_data.
    send(0, 8'hF0, 1'b0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(0, 8'h0F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'($urandom);
      tick();
    end
    in_valid[0] = 1'b0;
    drain(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
